dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/sat_counter.sv | 29 ++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: the FSM state encoding and
// the default parameter values.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF       = 9;
    localparam int STARVE_LIMIT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HOST_ISSUE = 2'd1,
        HOST_DONE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear; at_limit flags when the
// count has reached LIMIT.
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    assign at_limit = (count == LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the Dcache BRAM between the CPU MEM stage and a host interface.
// The CPU has priority; a waiting host is forced in after STARVE_LIMIT denials.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_ack,
    output logic [31:0]       host_rdata,
    output logic [ADDR_W-1:0] mem_addra,
    output logic              mem_ena,
    output logic [ADDR_W-1:0] mem_addrb,
    output logic              mem_enb,
    output logic              mem_web,
    output logic [31:0]       mem_dinb,
    input  logic [31:0]       mem_douta
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              starve_at_limit;
    logic              cpu_busy;
    logic              grant;
    logic [ADDR_W-1:0] cpu_word;
    logic              unused_bits;

    assign cpu_busy    = cpu_ren | cpu_wen;
    assign cpu_word    = cpu_addr[ADDR_W+1:2];
    assign cpu_rdata   = mem_douta;
    assign unused_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0], starve_cnt};

    // The grant cycle itself still serves the CPU; the host owns the ports
    // only in the following HOST_ISSUE cycle.
    assign grant = (state == IDLE) && host_req && (!cpu_busy || starve_at_limit);

    sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      ((state == IDLE) && host_req && !grant),
        .clr      (grant),
        .count    (starve_cnt),
        .at_limit (starve_at_limit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // BRAM output lands in HOST_DONE for a read issued in HOST_ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            host_rdata <= '0;
        end else if (state == HOST_DONE && !host_we) begin
            host_rdata <= mem_douta;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_addra = cpu_word;
        mem_addrb = cpu_word;
        mem_ena   = cpu_ren;
        mem_enb   = cpu_wen;
        mem_web   = cpu_wen;
        mem_dinb  = cpu_wdata;
        cpu_stall = 1'b0;
        host_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = HOST_ISSUE;
                end
            end
            HOST_ISSUE: begin
                mem_addra = host_addr;
                mem_addrb = host_addr;
                mem_ena   = !host_we;
                mem_enb   = host_we;
                mem_web   = host_we;
                mem_dinb  = host_wdata;
                cpu_stall = cpu_busy;
                state_nxt = HOST_DONE;
            end
            HOST_DONE: begin
                host_ack  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Reset silences every strobe immediately, even mid host access.
        if (!rst_n) begin
            mem_ena   = 1'b0;
            mem_enb   = 1'b0;
            mem_web   = 1'b0;
            cpu_stall = 1'b0;
            host_ack  = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: BRAM model, a reference memory with
// scoreboard queues, a table of CPU-only vectors and hand-written host sequences.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_ren;
    logic          cpu_wen;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata;
    logic          host_ack;
    logic [31:0]   host_rdata;
    logic [AW-1:0] mem_addra;
    logic          mem_ena;
    logic [AW-1:0] mem_addrb;
    logic          mem_enb;
    logic          mem_web;
    logic [31:0]   mem_dinb;
    logic [31:0]   mem_douta;

    logic [31:0] bram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic [31:0] cpu_q [$];
    logic [31:0] host_q [$];
    logic        last_ack;
    logic        last_stall;
    int          total = 0;
    int          bad   = 0;

    typedef struct {
        logic          ren;
        logic          wen;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic          exp_ena;
        logic          exp_enb;
        logic [AW-1:0] exp_word;
    } vec_t;

    vec_t vecs [6];

    dmem_arbiter #(
        .ADDR_W       (AW),
        .STARVE_LIMIT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_ren    (cpu_ren),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_addra  (mem_addra),
        .mem_ena    (mem_ena),
        .mem_addrb  (mem_addrb),
        .mem_enb    (mem_enb),
        .mem_web    (mem_web),
        .mem_dinb   (mem_dinb),
        .mem_douta  (mem_douta)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (i == 5) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Read-first BRAM, reloaded with known contents whenever reset is low.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << AW); i++) bram[i] <= init_val(i);
        end else begin
            if (mem_enb && mem_web) bram[mem_addrb] <= mem_dinb;
            if (mem_ena) mem_douta <= bram[mem_addra];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ren, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        cpu_ren   = ren;
        cpu_wen   = wen;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic reset_ref();
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    endtask

    // One clock: sample mid-cycle, push expectations, then pop and compare
    // the registered results just after the next rising edge.
    task automatic cycle();
        logic pc;
        logic ph;
        pc = 1'b0;
        ph = 1'b0;
        #3;
        last_ack   = host_ack;
        last_stall = cpu_stall;
        if (rst_n) begin
            if (host_ack && !host_we) begin
                host_q.push_back(ref_mem[host_addr]);
                ph = 1'b1;
            end
            if (host_ack && host_we) ref_mem[host_addr] = host_wdata;
            if (cpu_ren && !cpu_stall) begin
                cpu_q.push_back(ref_mem[cpu_addr[AW+1:2]]);
                pc = 1'b1;
            end
            if (cpu_wen && !cpu_stall) ref_mem[cpu_addr[AW+1:2]] = cpu_wdata;
        end
        @(posedge clk);
        #1;
        if (pc) checkOutput("sb_cpu_rdata", cpu_rdata, cpu_q.pop_front());
        if (ph) checkOutput("sb_host_rdata", host_rdata, host_q.pop_front());
    endtask

    task automatic host_txn(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic busy, output int lat, output int stalls);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        applyStimulus(busy, 1'b0, 32'h0000_0040, 32'h0);
        lat    = -1;
        stalls = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            if (last_stall) stalls++;
            if (last_ack) begin
                lat = i;
                break;
            end
        end
        host_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0000_0040, 32'h0);
        if (lat < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL host_txn_timeout: got no ack expected ack within 32 cycles");
        end
    endtask

    initial begin
        int lat;
        int stalls;
        int acks [$];

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,          1'b1, 1'b0, 9'h005};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222,  1'b0, 1'b1, 9'h008};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h3333_4444,  1'b1, 1'b1, 9'h008};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          1'b1, 1'b0, 9'h008};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_F804, 32'h0,          1'b1, 1'b0, 9'h001};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_07FC, 32'h5555_AAAA,  1'b0, 1'b0, 9'h1FF};

        reset_ref();
        rst_n      = 1'b0;
        host_req   = 1'b1;
        host_we    = 1'b0;
        host_addr  = 9'h005;
        host_wdata = 32'h0;
        applyStimulus(1'b1, 1'b1, 32'h0000_0014, 32'h0);

        // Reset with every request asserted: all strobes stay quiet.
        @(posedge clk);
        #1;
        @(posedge clk);
        #4;
        checkOutput("rst_host_ack", 32'(host_ack), 32'h0);
        checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'h0);
        checkOutput("rst_mem_ena", 32'(mem_ena), 32'h0);
        checkOutput("rst_mem_enb", 32'(mem_enb), 32'h0);
        checkOutput("rst_host_rdata", host_rdata, 32'h0);
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        host_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // CPU-only vectors: the CPU owns both ports and is never stalled.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k].ren, vecs[k].wen, vecs[k].addr, vecs[k].wdata);
            #3;
            checkOutput("tbl_ena", 32'(mem_ena), 32'(vecs[k].exp_ena));
            checkOutput("tbl_enb", 32'(mem_enb), 32'(vecs[k].exp_enb));
            checkOutput("tbl_web", 32'(mem_web), 32'(vecs[k].exp_enb));
            checkOutput("tbl_addra", 32'(mem_addra), 32'(vecs[k].exp_word));
            checkOutput("tbl_addrb", 32'(mem_addrb), 32'(vecs[k].exp_word));
            checkOutput("tbl_dinb", mem_dinb, vecs[k].wdata);
            checkOutput("tbl_stall", 32'(cpu_stall), 32'h0);
            cycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // Host read with an idle CPU.
        host_txn(1'b0, 9'h005, 32'h0, 1'b0, lat, stalls);
        checkOutput("idle_read_latency", 32'(lat), 32'd2);
        checkOutput("idle_read_stalls", 32'(stalls), 32'd0);
        checkOutput("idle_read_data", host_rdata, 32'hDEAD_BEEF);

        // CPU loads every cycle: host forced in after 8 denials.
        host_txn(1'b0, 9'h005, 32'h0, 1'b1, lat, stalls);
        checkOutput("starve_latency", 32'(lat), 32'd10);
        checkOutput("starve_stalls", 32'(stalls), 32'd1);
        checkOutput("starve_cnt_clear", 32'(dut.starve_cnt), 32'h0);

        // Host write, then a CPU load of the same word.
        host_txn(1'b1, 9'h1FF, 32'h1234_5678, 1'b0, lat, stalls);
        checkOutput("host_write_latency", 32'(lat), 32'd2);
        applyStimulus(1'b1, 1'b0, 32'h0000_07FC, 32'h0);
        cycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("cpu_load_after_host_wr", cpu_rdata, 32'h1234_5678);

        // CPU store collides with a host read request of the same word.
        host_req   = 1'b1;
        host_we    = 1'b0;
        host_addr  = 9'h002;
        host_wdata = 32'h0;
        applyStimulus(1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5);
        cycle();
        checkOutput("collide_store_stall", 32'(last_stall), 32'h0);
        checkOutput("collide_early_ack", 32'(last_ack), 32'h0);
        host_txn(1'b0, 9'h002, 32'h0, 1'b0, lat, stalls);
        checkOutput("collide_latency", 32'(lat), 32'd2);
        checkOutput("collide_host_data", host_rdata, 32'hA5A5_A5A5);

        // Reset while the host access is in HOST_ISSUE.
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 9'h005;
        cycle();
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0014, 32'h0);
        #3;
        checkOutput("midrst_stall", 32'(cpu_stall), 32'h0);
        checkOutput("midrst_ack", 32'(host_ack), 32'h0);
        checkOutput("midrst_ena", 32'(mem_ena), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        host_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        reset_ref();
        checkOutput("midrst_state", 32'(dut.state), 32'(IDLE));
        checkOutput("midrst_host_rdata", host_rdata, 32'h0);
        cycle();
        checkOutput("midrst_no_ack", 32'(last_ack), 32'h0);
        checkOutput("midrst_no_stall", 32'(last_stall), 32'h0);

        // Back-to-back host reads: one ack every third cycle.
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 9'h005;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (last_ack) acks.push_back(i);
        end
        host_req = 1'b0;
        checkOutput("b2b_ack_count", 32'(acks.size()), 32'd4);
        for (int k = 0; k < acks.size(); k++) begin
            checkOutput("b2b_ack_pos", 32'(acks[k]), 32'(2 + 3 * k));
        end
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
